// File: rtl/spi_m_byte_sequencer_pkg.sv
// Shared types and constants for the SPI master byte sequencer slice.
package spi_m_byte_sequencer_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ISSUE,
      WAIT_RX,
      DONE
   } seq_state_t;

   // Occupancy counter width: one extra bit so a full FIFO is distinguishable from empty.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/spi_m_byte_sequencer_if.sv
// Bundles the upstream burst interface and the single-byte master handshake.
// The slave modport is the sequencer's view; master is the view of whoever drives it.
interface spi_m_byte_sequencer_if #(
   parameter int LEN_W = 8
) ();
   import spi_m_byte_sequencer_pkg::*;

   logic [BYTE_W-1:0] wr_byte;
   logic              wr_dv;
   logic              wr_full;
   logic              start;
   logic [LEN_W-1:0]  len;
   logic              busy;
   logic              done;
   logic              error;
   logic [BYTE_W-1:0] tx_byte;
   logic              tx_dv;
   logic              tx_ready;
   logic [BYTE_W-1:0] rx_byte;
   logic              rx_dv;
   logic              rd_en;
   logic [BYTE_W-1:0] rd_byte;
   logic              rd_empty;

   modport slave (
      input  wr_byte, wr_dv, start, len, tx_ready, rx_byte, rx_dv, rd_en,
      output wr_full, busy, done, error, tx_byte, tx_dv, rd_byte, rd_empty
   );

   modport master (
      output wr_byte, wr_dv, start, len, tx_ready, rx_byte, rx_dv, rd_en,
      input  wr_full, busy, done, error, tx_byte, tx_dv, rd_byte, rd_empty
   );

endinterface

// File: rtl/spi_m_byte_sequencer_fifo.sv
// Synchronous first-word-fall-through FIFO used for both the TX and RX byte queues.
// Full and empty come from the registered occupancy count; a push into a full FIFO
// is dropped even when a pop happens in the same cycle.
module spi_seq_fifo
   import spi_m_byte_sequencer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = cnt_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents need no reset because empty gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/spi_m_byte_sequencer.sv
// Multi-byte burst front end for the single-byte SPI master: queues outgoing bytes,
// issues them one at a time with a DV pulse, and collects each returned byte.
// Only one byte is ever outstanding; a silent master is aborted after RX_TIMEOUT cycles.
module spi_m_byte_sequencer
   import spi_m_byte_sequencer_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int LEN_W      = 8,
   parameter int RX_TIMEOUT = 1024
) (
   input logic                  clk,
   input logic                  rst_n,
   spi_m_byte_sequencer_if.slave bus
);

   localparam int TIMER_W = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;

   seq_state_t         state;
   seq_state_t         next_state;
   logic [LEN_W-1:0]   remaining;
   logic [TIMER_W-1:0] timer;
   logic               error_q;
   logic [BYTE_W-1:0]  tx_hold;

   logic               tx_full;
   logic               tx_empty;
   logic [BYTE_W-1:0]  tx_head;
   logic               tx_pop;
   logic               rx_full;
   logic               rx_empty;
   logic [BYTE_W-1:0]  rx_head;

   logic               start_ok;
   logic               rx_take;
   logic               timed_out;

   assign start_ok  = (state == IDLE) && bus.start;
   assign rx_take   = (state == WAIT_RX) && bus.rx_dv;
   assign timed_out = (state == WAIT_RX) && !bus.rx_dv && (timer == TIMER_W'(RX_TIMEOUT - 1));

   spi_seq_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (bus.wr_dv),
      .push_data (bus.wr_byte),
      .full      (tx_full),
      .pop       (tx_pop),
      .head      (tx_head),
      .empty     (tx_empty)
   );

   spi_seq_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rx_take),
      .push_data (bus.rx_byte),
      .full      (rx_full),
      .pop       (bus.rd_en),
      .head      (rx_head),
      .empty     (rx_empty)
   );

   // Sequencer state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state selection and the handshake outputs decoded from the current state.
   always_comb begin
      next_state   = state;
      tx_pop       = 1'b0;
      bus.tx_dv    = 1'b0;
      bus.done     = 1'b0;
      bus.busy     = (state != IDLE);
      bus.error    = error_q;
      bus.tx_byte  = tx_hold;
      bus.wr_full  = tx_full;
      bus.rd_empty = rx_empty;
      bus.rd_byte  = rx_empty ? '0 : rx_head;
      case (state)
         IDLE: begin
            if (bus.start) next_state = (bus.len != '0) ? LOAD : DONE;
         end
         LOAD: begin
            if (!tx_empty && bus.tx_ready) next_state = ISSUE;
         end
         ISSUE: begin
            tx_pop      = 1'b1;
            bus.tx_dv   = 1'b1;
            bus.tx_byte = tx_head;
            next_state  = WAIT_RX;
         end
         WAIT_RX: begin
            if (bus.rx_dv)     next_state = (remaining == LEN_W'(1)) ? DONE : LOAD;
            else if (timed_out) next_state = DONE;
         end
         DONE: begin
            bus.done   = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Burst bookkeeping: byte countdown, response timer, held TX byte and sticky error.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         remaining <= '0;
         timer     <= '0;
         error_q   <= 1'b0;
         tx_hold   <= '0;
      end else begin
         if (start_ok) begin
            remaining <= bus.len;
            error_q   <= 1'b0;
         end
         if (state == ISSUE) begin
            timer   <= '0;
            tx_hold <= tx_head;
         end else if (state == WAIT_RX) begin
            timer <= timer + TIMER_W'(1);
         end
         if (rx_take) remaining <= remaining - LEN_W'(1);
         if (timed_out || (rx_take && rx_full)) error_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_spi_m_byte_sequencer.sv
// Self-checking bench for spi_m_byte_sequencer with a stub byte master that echoes
// the inverted TX byte after a programmable delay.
module tb_spi_m_byte_sequencer;

   localparam int FIFO_DEPTH = 4;
   localparam int LEN_W      = 8;
   localparam int RX_TIMEOUT = 16;

   typedef struct {
      int              len;
      logic [5:0][7:0] data;
      int              delay;
      bit              exp_err;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   spi_m_byte_sequencer_if #(.LEN_W(LEN_W)) bus ();

   spi_m_byte_sequencer #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .LEN_W      (LEN_W),
      .RX_TIMEOUT (RX_TIMEOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int         vectors     = 0;
   int         miscompares = 0;
   logic [7:0] txq[$];
   logic [7:0] rxq[$];
   int         dv_count    = 0;
   int         done_count  = 0;
   bit         stub_en     = 1'b1;
   int         stub_delay  = 0;
   bit         stub_pending = 1'b0;
   int         stub_wait   = 0;
   logic [7:0] stub_byte   = 8'h00;
   vec_t       tbl[5];

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Observe DV pulses and done pulses; each issued byte must match the scoreboard head.
   always @(negedge clk) begin
      if (rst_n && bus.done) done_count++;
      if (rst_n && bus.tx_dv) begin
         dv_count++;
         if (txq.size() == 0) checkOutput("tx_dv unexpected", 1, 0);
         else                 checkOutput("tx_byte order", int'(bus.tx_byte), int'(txq.pop_front()));
      end
   end

   // Stub master: answers each DV with the inverted byte after stub_delay idle cycles.
   always @(posedge clk) begin
      #1;
      bus.rx_dv = 1'b0;
      if (stub_pending) begin
         if (stub_wait == 0) begin
            bus.rx_dv    = 1'b1;
            bus.rx_byte  = stub_byte;
            stub_pending = 1'b0;
         end else begin
            stub_wait--;
         end
      end
      if (bus.tx_dv && stub_en) begin
         stub_pending = 1'b1;
         stub_wait    = stub_delay;
         stub_byte    = ~bus.tx_byte;
      end
   end

   task automatic pushByte(input logic [7:0] b, input bit expect_rx);
      for (int i = 0; i < 200 && bus.wr_full; i++) tick();
      if (bus.wr_full) checkOutput("push wait full", 1, 0);
      bus.wr_byte = b;
      bus.wr_dv   = 1'b1;
      txq.push_back(b);
      if (expect_rx) rxq.push_back(~b);
      tick();
      bus.wr_dv = 1'b0;
   endtask

   task automatic startXfer(input int len);
      bus.start = 1'b1;
      bus.len   = LEN_W'(len);
      tick();
      bus.start = 1'b0;
   endtask

   task automatic waitDone(input int budget, output int cycles);
      cycles = -1;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (bus.done) begin
            cycles = c;
            break;
         end
         tick();
      end
      if (cycles < 0) checkOutput("done within budget", 0, 1);
      else            tick();
   endtask

   task automatic drainRx();
      for (int i = 0; i < 2 * FIFO_DEPTH && !bus.rd_empty; i++) begin
         if (rxq.size() == 0) checkOutput("rx extra byte", 1, 0);
         else                 checkOutput("rx byte", int'(bus.rd_byte), int'(rxq.pop_front()));
         bus.rd_en = 1'b1;
         tick();
         bus.rd_en = 1'b0;
      end
      checkOutput("rx leftover expected", rxq.size(), 0);
      rxq.delete();
   endtask

   task automatic applyStimulus(input vec_t v);
      int nxt = 0;
      int dv0 = dv_count;
      int dn0 = done_count;
      int cyc = -1;
      stub_delay = v.delay;
      stub_en    = 1'b1;
      while (nxt < v.len && nxt < FIFO_DEPTH) begin
         pushByte(v.data[nxt], 1'b1);
         nxt++;
      end
      startXfer(v.len);
      for (int c = 0; c < 1000; c++) begin
         if (nxt < v.len && !bus.wr_full) begin
            bus.wr_byte = v.data[nxt];
            bus.wr_dv   = 1'b1;
            txq.push_back(v.data[nxt]);
            if (nxt < FIFO_DEPTH) rxq.push_back(~v.data[nxt]);
            nxt++;
         end
         @(negedge clk);
         if (bus.done) cyc = c;
         tick();
         bus.wr_dv = 1'b0;
         if (cyc >= 0) break;
      end
      checkOutput("vec done seen", int'(cyc >= 0), 1);
      checkOutput("vec done count", done_count - dn0, 1);
      checkOutput("vec dv count", dv_count - dv0, v.len);
      checkOutput("vec error", int'(bus.error), int'(v.exp_err));
      checkOutput("vec busy after done", int'(bus.busy), 0);
      drainRx();
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int dv0;
      int dn0;
      int cyc;
      int dvc;
      int donec;

      bus.wr_byte  = 8'h00;
      bus.wr_dv    = 1'b0;
      bus.start    = 1'b0;
      bus.len      = '0;
      bus.tx_ready = 1'b1;
      bus.rd_en    = 1'b0;
      rst_n        = 1'b0;

      tbl[0] = '{len: 3, data: {8'h00, 8'h00, 8'h00, 8'hFF, 8'h3C, 8'hA5}, delay: 0,  exp_err: 1'b0};
      tbl[1] = '{len: 1, data: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, delay: 5,  exp_err: 1'b0};
      tbl[2] = '{len: 4, data: {8'h00, 8'h00, 8'h08, 8'h04, 8'h02, 8'h01}, delay: 2,  exp_err: 1'b0};
      tbl[3] = '{len: 6, data: {8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10}, delay: 0,  exp_err: 1'b1};
      tbl[4] = '{len: 2, data: {8'h00, 8'h00, 8'h00, 8'h00, 8'h7E, 8'h80}, delay: 15, exp_err: 1'b0};

      // Reset state.
      repeat (3) tick();
      @(negedge clk);
      checkOutput("reset busy", int'(bus.busy), 0);
      checkOutput("reset done", int'(bus.done), 0);
      checkOutput("reset error", int'(bus.error), 0);
      checkOutput("reset tx_dv", int'(bus.tx_dv), 0);
      checkOutput("reset tx_byte", int'(bus.tx_byte), 0);
      checkOutput("reset wr_full", int'(bus.wr_full), 0);
      checkOutput("reset rd_empty", int'(bus.rd_empty), 1);
      checkOutput("reset rd_byte", int'(bus.rd_byte), 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Table-driven bursts: ordering, RX delays, overflow and the last-cycle response.
      for (int i = 0; i < 5; i++) applyStimulus(tbl[i]);

      // Zero-length start: done one cycle later, busy for exactly one cycle, nothing issued.
      dv0 = dv_count;
      dn0 = done_count;
      bus.start = 1'b1;
      bus.len   = '0;
      @(negedge clk);
      checkOutput("len0 busy before", int'(bus.busy), 0);
      tick();
      bus.start = 1'b0;
      @(negedge clk);
      checkOutput("len0 busy", int'(bus.busy), 1);
      checkOutput("len0 done", int'(bus.done), 1);
      tick();
      @(negedge clk);
      checkOutput("len0 busy after", int'(bus.busy), 0);
      checkOutput("len0 done after", int'(bus.done), 0);
      tick();
      checkOutput("len0 no dv", dv_count - dv0, 0);
      checkOutput("len0 one done", done_count - dn0, 1);

      // Empty TX FIFO and a not-ready master both stall LOAD; a second start is ignored.
      stub_delay   = 1;
      dv0          = dv_count;
      dn0          = done_count;
      bus.tx_ready = 1'b0;
      startXfer(2);
      repeat (50) tick();
      checkOutput("stall busy", int'(bus.busy), 1);
      checkOutput("stall no dv", dv_count - dv0, 0);
      checkOutput("stall no error", int'(bus.error), 0);
      startXfer(5);
      pushByte(8'h11, 1'b1);
      repeat (5) tick();
      checkOutput("not ready no dv", dv_count - dv0, 0);
      bus.tx_ready = 1'b1;
      pushByte(8'h22, 1'b1);
      waitDone(200, cyc);
      checkOutput("stall dv count", dv_count - dv0, 2);
      checkOutput("stall done count", done_count - dn0, 1);
      checkOutput("stall error", int'(bus.error), 0);
      drainRx();

      // Silent master: abort after RX_TIMEOUT waiting cycles, then a new start clears the error.
      stub_en = 1'b0;
      dvc     = -1;
      donec   = -1;
      pushByte(8'h77, 1'b0);
      startXfer(1);
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (bus.tx_dv) dvc = c;
         if (dvc >= 0 && c == dvc + 5) checkOutput("tx_byte held", int'(bus.tx_byte), 8'h77);
         if (bus.done) begin
            donec = c;
            break;
         end
         tick();
      end
      if (donec >= 0) begin
         checkOutput("timeout done spacing", donec - dvc, RX_TIMEOUT + 1);
         checkOutput("timeout error", int'(bus.error), 1);
         tick();
      end else begin
         checkOutput("timeout done seen", 0, 1);
      end
      checkOutput("timeout rx empty", int'(bus.rd_empty), 1);
      stub_en = 1'b1;
      startXfer(0);
      checkOutput("error cleared by start", int'(bus.error), 0);
      waitDone(10, cyc);

      // Reset during WAIT_RX aborts at once; the late echo arriving in IDLE is dropped.
      stub_delay = 10;
      dn0        = done_count;
      for (int i = 0; i < 4; i++) pushByte(8'hC0 + 8'(i), 1'b1);
      checkOutput("tx full at depth", int'(bus.wr_full), 1);
      startXfer(4);
      dvc = -1;
      for (int c = 0; c < 50 && dvc < 0; c++) begin
         @(negedge clk);
         if (bus.tx_dv) dvc = c;
         tick();
      end
      checkOutput("reset test dv seen", int'(dvc >= 0), 1);
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      @(negedge clk);
      checkOutput("midreset busy", int'(bus.busy), 0);
      checkOutput("midreset rd_empty", int'(bus.rd_empty), 1);
      checkOutput("midreset wr_full", int'(bus.wr_full), 0);
      checkOutput("midreset done", int'(bus.done), 0);
      tick();
      rst_n = 1'b1;
      txq.delete();
      rxq.delete();
      repeat (12) tick();
      checkOutput("midreset no done", done_count - dn0, 0);
      checkOutput("stray rx_dv ignored", int'(bus.rd_empty), 1);
      checkOutput("idle after reset", int'(bus.busy), 0);

      // Normal operation resumes after the abort.
      applyStimulus(tbl[0]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
